pmic_power_sequencer: RTL and testbench

Sequences five PMIC rail enables in order (power-up) and reverse order (power-down). Drives the 3-bit step select of the existing delay-table mux and counts out the returned per-step delay in ticks. Sits between the board-level start/stop controls and the rail enable pins.

---
 rtl/pmic_pkg.sv | 42 ++++
 rtl/pmic_tick_prescaler.sv | 39 +++
 rtl/pmic_power_sequencer.sv | 256 +++++++++++++++++++++++++
 tb/tb_pmic_power_sequencer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pmic_pkg.sv
// pmic_pkg: shared types and constants for the PMIC power sequencer.
//   state_t          - sequencer FSM states
//   NUM_RAILS        - number of sequenced rails (fixed at 5 by the delay table)
//   SEL_*            - step-select codes driven to the external delay-table mux
//   DEFAULT_TICK_DIV - clk cycles per delay tick (1 s at 100 MHz)
//   rail_bit()       - one-hot rail mask for a 1-based step number
//   top_rail()       - 1-based index of the highest enabled rail, 0 if none
package pmic_pkg;

  localparam int NUM_RAILS = 5;
  localparam int unsigned DEFAULT_TICK_DIV = 100_000_000;

  localparam logic [2:0] SEL_IDLE  = 3'b000;
  localparam logic [2:0] SEL_STEP1 = 3'b001;
  localparam logic [2:0] SEL_STEP2 = 3'b010;
  localparam logic [2:0] SEL_STEP3 = 3'b011;
  localparam logic [2:0] SEL_STEP4 = 3'b100;
  localparam logic [2:0] SEL_STEP5 = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_WAIT    = 3'd2,
    ST_ON      = 3'd3,
    ST_PD_LOAD = 3'd4,
    ST_PD_WAIT = 3'd5,
    ST_FAULT   = 3'd6
  } state_t;

  // Step k (1..5) owns rail k-1. Step 0 shifts the bit out and yields 0.
  function automatic logic [NUM_RAILS-1:0] rail_bit(input logic [2:0] step);
    rail_bit = NUM_RAILS'(1) << (step - 3'd1);
  endfunction

  function automatic logic [2:0] top_rail(input logic [NUM_RAILS-1:0] en);
    top_rail = SEL_IDLE;
    for (int i = 0; i < NUM_RAILS; i++) begin
      if (en[i]) top_rail = 3'(i + 1);
    end
  endfunction

endpackage

// File: rtl/pmic_tick_prescaler.sv
// pmic_tick_prescaler: divides clk down to a one-cycle delay tick.
//   clk, rst_n - clock, asynchronous active-low reset
//   clr        - restart the count at 0 (wins over en)
//   en         - advance the count
//   tick       - high in the enabled cycle where the count is TICK_DIV-1
// The counter runs 0..TICK_DIV-1 and wraps, so a tick lands on every
// TICK_DIV-th enabled cycle after a clear. tick is not masked by clr so the
// cycle that both consumes the last tick and clears still sees it.
module pmic_tick_prescaler
  import pmic_pkg::*;
#(
  parameter int unsigned TICK_DIV = DEFAULT_TICK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;

  assign tick = en && (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      if (cnt_q == LAST) cnt_q <= '0;
      else               cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/pmic_power_sequencer.sv
// pmic_power_sequencer: orders five PMIC rail enables up and down.
//   clk, rst_n  - clock, asynchronous active-low reset (drops all rails at once)
//   start       - level, begins power-up when sampled in IDLE (stop low)
//   stop        - level, begins power-down from ON or aborts a power-up
//   clear_fault - pulse, FAULT -> IDLE
//   pg          - per-rail power-good (only used with PG_CHECK_EN)
//   dly_in      - per-step delay in ticks from the external mux
//   sel         - step select to the mux (0 idle, 1..5 = step)
//   rail_en     - rail enables, bit k belongs to step k+1
//   busy        - high in LOAD/WAIT/PD_LOAD/PD_WAIT
//   seq_done    - high in ON
//   fault       - sticky fault flag
//   dbg_state   - current FSM state (state_t encoding)
// Build option: define PG_CHECK_EN to enable power-good supervision. Without
// it pg is ignored, FAULT is unreachable and fault is tied low.
//
// Timing: the mux is combinational on the registered sel, so sel is set on
// the edge that enters LOAD/PD_LOAD and dly_in is valid in that cycle. A WAIT
// lasts exactly dly*TICK_DIV cycles (one cycle for dly=0): it exits on the
// edge where the last tick brings cnt from 1 to 0, or immediately if cnt
// was loaded as 0.
module pmic_power_sequencer
  import pmic_pkg::*;
#(
  parameter int unsigned TICK_DIV = DEFAULT_TICK_DIV,
  parameter int          CNT_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 clear_fault,
  input  logic [NUM_RAILS-1:0] pg,
  input  logic [CNT_W-1:0]     dly_in,
  output logic [2:0]           sel,
  output logic [NUM_RAILS-1:0] rail_en,
  output logic                 busy,
  output logic                 seq_done,
  output logic                 fault,
  output logic [2:0]           dbg_state
);

  state_t               state_q, state_d;
  logic [2:0]           step_q, step_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           sel_q, sel_d;
  logic [NUM_RAILS-1:0] rail_en_q, rail_en_d;
  logic                 busy_q, done_q;

  logic presc_clr, presc_en, tick;
  logic wait_done, abort;
  logic [2:0] abort_step;

  // Power-good supervision results, constant 0 when the option is off.
  logic pg_fault_wait, pg_fault_on, pg_on_presc_en;

  pmic_tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (presc_clr),
    .en    (presc_en),
    .tick  (tick)
  );

  assign wait_done  = (cnt_q == '0) || (tick && (cnt_q == CNT_W'(1)));
  assign abort      = stop && ((state_q == ST_LOAD) || (state_q == ST_WAIT));
  // Abort powers down from the highest rail already up; none up -> IDLE.
  assign abort_step = top_rail(rail_en_q);

`ifdef PG_CHECK_EN
  logic [NUM_RAILS-1:0] pg_meta_q, pg_s_q;
  logic                 pg5_pend_q;
  logic [NUM_RAILS-1:0] low_q, low_d;

  // Rail 5 has no successor, so its power-good gets one tick after ON entry.
  // While that window is open it is excluded from the steady-state check.
  assign pg_on_presc_en = pg5_pend_q;
  assign low_d = (state_q == ST_ON)
               ? (rail_en_q & ~pg_s_q & ~(pg5_pend_q ? rail_bit(SEL_STEP5) : '0))
               : '0;
  // At the expiry of step k's WAIT, the rail of step k-1 must be good.
  assign pg_fault_wait = (state_q == ST_WAIT) && wait_done && (step_q != SEL_STEP1)
                       && |(rail_bit(step_q - 3'd1) & ~pg_s_q);
  assign pg_fault_on   = (state_q == ST_ON)
                       && ((pg5_pend_q && tick && !pg_s_q[NUM_RAILS-1]) || |(low_d & low_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pg_meta_q  <= '0;
      pg_s_q     <= '0;
      pg5_pend_q <= 1'b0;
      low_q      <= '0;
    end else begin
      pg_meta_q <= pg;
      pg_s_q    <= pg_meta_q;
      low_q     <= low_d;
      if ((state_q == ST_WAIT) && (state_d == ST_ON)) pg5_pend_q <= 1'b1;
      else if ((state_q != ST_ON) || tick)            pg5_pend_q <= 1'b0;
    end
  end
`else
  logic unused_pg;
  assign unused_pg      = ^pg;
  assign pg_fault_wait  = 1'b0;
  assign pg_fault_on    = 1'b0;
  assign pg_on_presc_en = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    rail_en_d = rail_en_q;
    presc_clr = 1'b0;
    presc_en  = 1'b0;

    if (abort) begin
      if (abort_step == SEL_IDLE) begin
        state_d = ST_IDLE;
        step_d  = SEL_STEP1;
        sel_d   = SEL_IDLE;
      end else begin
        state_d = ST_PD_LOAD;
        step_d  = abort_step;
        sel_d   = abort_step;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          sel_d = SEL_IDLE;
          if (start && !stop) begin
            step_d  = SEL_STEP1;
            sel_d   = SEL_STEP1;
            state_d = ST_LOAD;
          end
        end
        ST_LOAD: begin
          presc_clr = 1'b1;
          cnt_d     = dly_in;
          state_d   = ST_WAIT;
        end
        ST_WAIT: begin
          presc_en = 1'b1;
          if (tick && (cnt_q != '0)) cnt_d = cnt_q - CNT_W'(1);
          if (wait_done) begin
            if (pg_fault_wait) begin
              state_d   = ST_FAULT;
              step_d    = SEL_STEP1;
              sel_d     = SEL_IDLE;
              rail_en_d = '0;
            end else begin
              rail_en_d = rail_en_q | rail_bit(step_q);
              if (step_q == SEL_STEP5) begin
                state_d   = ST_ON;
                sel_d     = SEL_STEP5;
                presc_clr = 1'b1;
              end else begin
                step_d  = step_q + 3'd1;
                sel_d   = step_q + 3'd1;
                state_d = ST_LOAD;
              end
            end
          end
        end
        ST_ON: begin
          sel_d    = SEL_STEP5;
          presc_en = pg_on_presc_en;
          if (pg_fault_on) begin
            state_d   = ST_FAULT;
            step_d    = SEL_STEP1;
            sel_d     = SEL_IDLE;
            rail_en_d = '0;
          end else if (stop) begin
            state_d = ST_PD_LOAD;
            step_d  = SEL_STEP5;
            sel_d   = SEL_STEP5;
          end
        end
        ST_PD_LOAD: begin
          presc_clr = 1'b1;
          cnt_d     = dly_in;
          state_d   = ST_PD_WAIT;
        end
        ST_PD_WAIT: begin
          presc_en = 1'b1;
          if (tick && (cnt_q != '0)) cnt_d = cnt_q - CNT_W'(1);
          if (wait_done) begin
            rail_en_d = rail_en_q & ~rail_bit(step_q);
            if (step_q == SEL_STEP1) begin
              state_d = ST_IDLE;
              sel_d   = SEL_IDLE;
            end else begin
              step_d  = step_q - 3'd1;
              sel_d   = step_q - 3'd1;
              state_d = ST_PD_LOAD;
            end
          end
        end
        ST_FAULT: begin
          rail_en_d = '0;
          sel_d     = SEL_IDLE;
          if (clear_fault) begin
            state_d = ST_IDLE;
            step_d  = SEL_STEP1;
          end
        end
        default: begin
          state_d   = ST_IDLE;
          step_d    = SEL_STEP1;
          sel_d     = SEL_IDLE;
          rail_en_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      step_q    <= SEL_STEP1;
      cnt_q     <= '0;
      sel_q     <= SEL_IDLE;
      rail_en_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      rail_en_q <= rail_en_d;
      busy_q    <= (state_d == ST_LOAD) || (state_d == ST_WAIT)
                || (state_d == ST_PD_LOAD) || (state_d == ST_PD_WAIT);
      done_q    <= (state_d == ST_ON);
    end
  end

`ifdef PG_CHECK_EN
  logic fault_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fault_q <= 1'b0;
    else        fault_q <= (state_d == ST_FAULT);
  end
  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  assign sel       = sel_q;
  assign rail_en   = rail_en_q;
  assign busy      = busy_q;
  assign seq_done  = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_pmic_power_sequencer.sv
// tb_pmic_power_sequencer: directed bench for pmic_power_sequencer with
// TICK_DIV=4 and a modelled delay-table mux returning 5,6,5,3,3 for steps 1..5.
// Time t counts rising edges since the scenario's stimulus was applied;
// inputs change and outputs are sampled 1 ns after a rising edge.
module tb_pmic_power_sequencer;
  import pmic_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start, stop, clear_fault;
  logic [4:0]  pg;
  logic [31:0] dly_in;
  logic [2:0]  sel;
  logic [4:0]  rail_en;
  logic        busy, seq_done, fault;
  logic [2:0]  dbg_state;

  logic        zero_dly;
  logic        pg_all;
  logic [4:0]  pg_mask;

  int n_total = 0;
  int n_pass  = 0;
  int t       = 0;

  pmic_power_sequencer #(.TICK_DIV(4), .CNT_W(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stop        (stop),
    .clear_fault (clear_fault),
    .pg          (pg),
    .dly_in      (dly_in),
    .sel         (sel),
    .rail_en     (rail_en),
    .busy        (busy),
    .seq_done    (seq_done),
    .fault       (fault),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- environment models ----------------
  function automatic logic [31:0] dly_tab(input logic [2:0] s);
    case (s)
      3'd1:    dly_tab = 32'd5;
      3'd2:    dly_tab = 32'd6;
      3'd3:    dly_tab = 32'd5;
      3'd4:    dly_tab = 32'd3;
      3'd5:    dly_tab = 32'd3;
      default: dly_tab = 32'd9;
    endcase
  endfunction

  assign dly_in = zero_dly ? 32'd0 : dly_tab(sel);
  assign pg     = pg_all ? 5'b11111 : (rail_en & pg_mask);

  // ---------------- driver tasks ----------------
  task automatic adv(input int target);
    while (t < target) begin
      @(posedge clk);
      #1;
      t++;
    end
  endtask

  task automatic begin_scenario();
    t = 0;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else             n_pass++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    stop        = 1'b0;
    clear_fault = 1'b0;
    zero_dly    = 1'b0;
    pg_all      = 1'b0;
    pg_mask     = 5'b11111;
    do_reset();

    // Reset values
    check("rst_state", dbg_state, ST_IDLE);
    check("rst_sel", sel, 3'd0);
    check("rst_rail", rail_en, 5'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", seq_done, 1'b0);
    check("rst_fault", fault, 1'b0);

    // Power-up: rails at 22, 47, 68, 81, 94
    begin_scenario();
    start = 1'b1;
    adv(1);
    start = 1'b0;
    check("pu_t1_state", dbg_state, ST_LOAD);
    check("pu_t1_sel", sel, 3'd1);
    check("pu_t1_busy", busy, 1'b1);
    adv(21); check("pu_t21_rail", rail_en, 5'b00000);
    adv(22); check("pu_t22_rail", rail_en, 5'b00001);
    check("pu_t22_sel", sel, 3'd2);
    adv(46); check("pu_t46_rail", rail_en, 5'b00001);
    adv(47); check("pu_t47_rail", rail_en, 5'b00011);
    check("pu_t47_sel", sel, 3'd3);
    adv(67); check("pu_t67_rail", rail_en, 5'b00011);
    adv(68); check("pu_t68_rail", rail_en, 5'b00111);
    adv(80); check("pu_t80_rail", rail_en, 5'b00111);
    adv(81); check("pu_t81_rail", rail_en, 5'b01111);
    check("pu_t81_sel", sel, 3'd5);
    adv(93); check("pu_t93_done", seq_done, 1'b0);
    adv(94); check("pu_t94_rail", rail_en, 5'b11111);
    check("pu_t94_done", seq_done, 1'b1);
    check("pu_t94_busy", busy, 1'b0);
    check("pu_t94_sel", sel, 3'd5);
    check("pu_t94_state", dbg_state, ST_ON);

    // Power-down: stop sampled at edge 101, clears at 114,127,148,173,194
    adv(100);
    check("on_hold_done", seq_done, 1'b1);
    stop = 1'b1;
    adv(101);
    stop = 1'b0;
    check("pd_t101_state", dbg_state, ST_PD_LOAD);
    check("pd_t101_sel", sel, 3'd5);
    adv(113); check("pd_t113_rail", rail_en, 5'b11111);
    adv(114); check("pd_t114_rail", rail_en, 5'b01111);
    adv(126); check("pd_t126_rail", rail_en, 5'b01111);
    adv(127); check("pd_t127_rail", rail_en, 5'b00111);
    adv(148); check("pd_t148_rail", rail_en, 5'b00011);
    adv(172); check("pd_t172_rail", rail_en, 5'b00011);
    adv(173); check("pd_t173_rail", rail_en, 5'b00001);
    adv(193); check("pd_t193_busy", busy, 1'b1);
    adv(194); check("pd_t194_rail", rail_en, 5'b00000);
    check("pd_t194_sel", sel, 3'd0);
    check("pd_t194_busy", busy, 1'b0);
    check("pd_t194_state", dbg_state, ST_IDLE);
    adv(197);

    // Abort: stop sampled at edge 30 with rail 0 up, rail 0 clears at 51
    begin_scenario();
    start = 1'b1;
    adv(1);
    start = 1'b0;
    adv(29);
    stop = 1'b1;
    adv(30);
    stop = 1'b0;
    check("ab_t30_state", dbg_state, ST_PD_LOAD);
    check("ab_t30_sel", sel, 3'd1);
    check("ab_t30_rail", rail_en, 5'b00001);
    adv(50); check("ab_t50_rail", rail_en, 5'b00001);
    adv(51); check("ab_t51_rail", rail_en, 5'b00000);
    check("ab_t51_state", dbg_state, ST_IDLE);
    check("ab_t51_busy", busy, 1'b0);
    adv(54);

    // Abort before any rail is up goes straight to IDLE
    begin_scenario();
    start = 1'b1;
    adv(1);
    start = 1'b0;
    adv(4);
    stop = 1'b1;
    adv(5);
    stop = 1'b0;
    check("ab0_state", dbg_state, ST_IDLE);
    check("ab0_sel", sel, 3'd0);
    adv(8);

    // Zero delay: rails at 3,5,7,9,11; power-down clears at 23..31
    zero_dly = 1'b1;
    pg_all   = 1'b1;
    begin_scenario();
    start = 1'b1;
    adv(1);
    start = 1'b0;
    adv(2);  check("zd_t2_rail", rail_en, 5'b00000);
    adv(3);  check("zd_t3_rail", rail_en, 5'b00001);
    adv(4);  check("zd_t4_rail", rail_en, 5'b00001);
    adv(5);  check("zd_t5_rail", rail_en, 5'b00011);
    adv(9);  check("zd_t9_rail", rail_en, 5'b01111);
    adv(11); check("zd_t11_rail", rail_en, 5'b11111);
    check("zd_t11_done", seq_done, 1'b1);
    adv(20);
    check("zd_t20_state", dbg_state, ST_ON);
    stop = 1'b1;
    adv(21);
    stop = 1'b0;
    adv(23); check("zd_t23_rail", rail_en, 5'b01111);
    adv(30); check("zd_t30_rail", rail_en, 5'b00001);
    adv(31); check("zd_t31_rail", rail_en, 5'b00000);
    check("zd_t31_state", dbg_state, ST_IDLE);
    zero_dly = 1'b0;
    pg_all   = 1'b0;
    adv(34);

    // start and stop together in IDLE: stop wins
    begin_scenario();
    start = 1'b1;
    stop  = 1'b1;
    adv(5);
    check("ss_state", dbg_state, ST_IDLE);
    check("ss_rail", rail_en, 5'b00000);
    check("ss_busy", busy, 1'b0);
    start = 1'b0;
    stop  = 1'b0;
    adv(7);

    // Asynchronous reset mid-WAIT of step 2
    begin_scenario();
    start = 1'b1;
    adv(1);
    start = 1'b0;
    adv(30);
    check("ar_pre_rail", rail_en, 5'b00001);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_rail", rail_en, 5'b00000);
    check("ar_sel", sel, 3'd0);
    check("ar_busy", busy, 1'b0);
    check("ar_state", dbg_state, ST_IDLE);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    adv(33);
    check("ar_after_state", dbg_state, ST_IDLE);

    // Rail 2 never reports power-good
    pg_mask = 5'b11101;
    begin_scenario();
    start = 1'b1;
    adv(1);
    start = 1'b0;
    adv(67);
    check("pgf_t67_rail", rail_en, 5'b00011);
    check("pgf_t67_fault", fault, 1'b0);
    adv(68);
`ifdef PG_CHECK_EN
    check("pgf_t68_rail", rail_en, 5'b00000);
    check("pgf_t68_fault", fault, 1'b1);
    check("pgf_t68_busy", busy, 1'b0);
    check("pgf_t68_state", dbg_state, ST_FAULT);
    adv(70);
    check("pgf_t70_fault", fault, 1'b1);
    clear_fault = 1'b1;
    adv(71);
    clear_fault = 1'b0;
    check("pgf_t71_state", dbg_state, ST_IDLE);
    check("pgf_t71_fault", fault, 1'b0);
`else
    check("pgf_t68_rail", rail_en, 5'b00111);
    check("pgf_t68_fault", fault, 1'b0);
    check("pgf_t68_state", dbg_state, ST_LOAD);
`endif
    pg_mask = 5'b11111;
    do_reset();

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
